// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, stability-counting debounce FSM,
// registered level plus press/release/long-press/auto-repeat pulses and a wrapping press counter.
// Latency: press/release accepted DEBOUNCE_CYCLES+2 edges after the first sampled pin change.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned LONG_PRESS_CYCLES = 64,
  parameter int unsigned REPEAT_CYCLES     = 16,
  parameter int unsigned REPEAT_EN         = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       button_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_press_o,
  output logic       repeat_o,
  output logic [7:0] press_count_o
);

  // Terminal values of the 16-bit counters (all parameters are 1..65535).
  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_CYCLES - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic [15:0] dcnt;
  logic [15:0] hold_cnt;
  logic [15:0] rep_cnt;
  logic        long_done;

  // Two-flop synchroniser; the FSM only ever looks at s2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button_i;
      s2 <= s1;
    end
  end

  // Debounce FSM; every output is a flop, pulses default low each cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      dcnt          <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      long_done     <= 1'b0;
      level_o       <= 1'b0;
      press_o       <= 1'b0;
      release_o     <= 1'b0;
      long_press_o  <= 1'b0;
      repeat_o      <= 1'b0;
      press_count_o <= '0;
    end else begin
      press_o      <= 1'b0;
      release_o    <= 1'b0;
      long_press_o <= 1'b0;
      repeat_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_CHK;
            dcnt  <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            // Bounce: drop back without any pulse.
            state <= IDLE;
          end else if (dcnt == DEB_LAST) begin
            state         <= HELD;
            press_o       <= 1'b1;
            level_o       <= 1'b1;
            press_count_o <= press_count_o + 8'd1;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            long_done     <= 1'b0;
          end else begin
            dcnt <= dcnt + 16'd1;
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_CHK;
            dcnt  <= '0;
          end else if (!long_done) begin
            if (hold_cnt == LONG_LAST) begin
              long_press_o <= 1'b1;
              long_done    <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end else if (REPEAT_EN != 0) begin
            // Wrap of rep_cnt marks one full repeat period since the last pulse.
            if (rep_cnt == REP_LAST) begin
              rep_cnt  <= '0;
              repeat_o <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 16'd1;
            end
          end
        end
        RELEASE_CHK: begin
          // Hold/repeat state is frozen here so a rejected release bounce resumes seamlessly.
          if (s2) begin
            state <= HELD;
          end else if (dcnt == DEB_LAST) begin
            state     <= IDLE;
            release_o <= 1'b1;
            level_o   <= 1'b0;
          end else begin
            dcnt <= dcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: two instances (repeat enabled / disabled)
// share clock, reset and pin; expected pulse timing is hand-derived per edge.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       level, press, release_p, long_press, repeat_p;
  logic [7:0] press_count;
  logic       nr_level, nr_press, nr_release, nr_long, nr_repeat;
  logic [7:0] nr_press_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press  = 0;
  int n_rel    = 0;
  int n_clash  = 0;
  int p_base, r_base;
  bit bounce [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .button_i(button),
    .level_o(level), .press_o(press), .release_o(release_p),
    .long_press_o(long_press), .repeat_o(repeat_p), .press_count_o(press_count)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(0)
  ) dut_nr (
    .clk_i(clk), .rst_i(rst), .button_i(button),
    .level_o(nr_level), .press_o(nr_press), .release_o(nr_release),
    .long_press_o(nr_long), .repeat_o(nr_repeat), .press_count_o(nr_press_count)
  );

  always #5 clk = ~clk;

  // Pulse tally on the enabled instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (press) n_press++;
      if (release_p) n_rel++;
      if ((press && release_p) || (press && (long_press || repeat_p))) n_clash++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b0;
    edges(2);
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_release", release_p, 0);
    chk("rst_long", long_press, 0);
    chk("rst_repeat", repeat_p, 0);
    chk("rst_count", press_count, 0);

    // Clean press: accepted after edge t0+6.
    rst = 1'b0;
    edges(2);
    button = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      edges(1);
      chk("t1_press", press, int'(k == 6));
      chk("t1_level", level, int'(k == 6));
    end
    chk("t1_count", press_count, 1);
    chk("t1_nr_count", nr_press_count, 1);

    // Hold: long press 10 edges after press, repeats every 3 edges after that.
    for (int j = 1; j <= 30; j++) begin
      edges(1);
      chk("t3_press", press, 0);
      chk("t3_long", long_press, int'(j == 10));
      chk("t3_repeat", repeat_p, int'(j >= 13 && (j - 10) % 3 == 0));
      chk("t6_nr_long", nr_long, int'(j == 10));
      chk("t6_nr_repeat", nr_repeat, 0);
    end

    // Release: first 0 sampled at edge P+31 (still a repeat slot), release 6 edges later.
    button = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      edges(1);
      chk("t3_release", release_p, int'(k == 6));
      chk("t3_level", level, int'(k < 6));
      chk("t3_rel_repeat", repeat_p, int'(k == 0));
      chk("t3_rel_long", long_press, 0);
      chk("t6_nr_release", nr_release, int'(k == 6));
      chk("t6_nr_level", nr_level, int'(k < 6));
    end

    // Press-side bounce is rejected.
    for (int i = 0; i < 14; i++) begin
      button = (i < 6) ? bounce[i] : 1'b0;
      edges(1);
      chk("t2_press", press, 0);
      chk("t2_level", level, 0);
    end
    chk("t2_count", press_count, 1);

    // Second real press, then release-side bounce is rejected.
    button = 1'b1;
    edges(10);
    chk("t2_held_level", level, 1);
    chk("t2_held_count", press_count, 2);
    for (int i = 0; i < 14; i++) begin
      button = (i < 6) ? !bounce[i] : 1'b1;
      edges(1);
      chk("t2_release", release_p, 0);
      chk("t2_rel_level", level, 1);
    end

    // Asynchronous reset mid-HELD, pin still high.
    #2 rst = 1'b1;
    #1;
    chk("t5_level", level, 0);
    chk("t5_count", press_count, 0);
    chk("t5_press", press, 0);
    chk("t5_long", long_press, 0);
    chk("t5_repeat", repeat_p, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      edges(1);
      chk("t5_repress", press, int'(k == 6));
    end
    chk("t5_recount", press_count, 1);

    // 256 press/release cycles from a fresh reset: counter wraps to 0.
    rst    = 1'b1;
    button = 1'b0;
    edges(2);
    rst = 1'b0;
    edges(2);
    p_base = n_press;
    r_base = n_rel;
    for (int i = 0; i < 256; i++) begin
      button = 1'b1;
      edges(12);
      button = 1'b0;
      edges(12);
      if (i == 254) chk("t4_count_255", press_count, 255);
    end
    chk("t4_count_wrap", press_count, 0);
    chk("t4_n_press", n_press - p_base, 256);
    chk("t4_n_release", n_rel - r_base, 256);
    chk("t4_clash", n_clash, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
